des_key_scheduler: RTL and testbench
====================================

// Module: des_key_scheduler
// PURPOSE
//   Sequences the DES key schedule and emits subkeys K1..K16 one per round.
//   Takes a 64-bit key, applies PC1, rotates C/D per round and feeds the existing PC2 permutation.
//   Supports encrypt order (K1 first) or decrypt order (K16 first).
//   Sits between the key-load interface and the round datapath, which consumes subkeys through a valid/ready handshake.
// PARAMETERS
//   NROUNDS   16   number of subkeys per key; fixed by DES, exposed only for the round counter width
// PORTS
//   clk           in   1      single clock; all state updates on rising edge
//   rst           in   1      synchronous, active-high reset
//   start         in   1      request a new schedule; sampled only in IDLE
//   decrypt       in   1      0: K1..K16 order, 1: K16..K1 order; captured with start
//   key           in   [1:64] DES key, bit 1 = MSB; parity bits 8,16..64 ignored; captured with start
//   abort         in   1      synchronous cancel of the current schedule
//   subkey        out  [1:48] current subkey = PC2(C,D) of registered C/D; bit 1 = MSB
//   subkey_valid  out  1      subkey is valid
//   subkey_ready  in   1      datapath accepts subkey this cycle
//   round_idx     out  [4:0]  1..16 = position in emission order; 0 in IDLE
//   busy          out  1      high from the cycle after start acceptance until the last handshake
//   done          out  1      one-cycle pulse the cycle after the 16th handshake
// BEHAVIOUR
//   Reset: state=IDLE, C=D=0, round_idx=0, subkey_valid=0, busy=0, done=0.
//     Reset wins over every other input.
//   States: IDLE -> ROUND -> IDLE. done is a registered pulse, not a separate state.
//   IDLE:
//     - start=1 at edge N: capture decrypt and the PC1 halves.
//     - Encrypt: {C,D} <= rotl(PC1(key), SHIFT[1]). Decrypt: {C,D} <= PC1(key), since C16 = C0.
//     - round_idx <= 1; enter ROUND. subkey_valid and busy are high from cycle N+1 (latency 1).
//   ROUND: subkey_valid=1; subkey, round_idx and decrypt are held stable until handshake.
//   Handshake (subkey_valid & subkey_ready) with round_idx = r < 16:
//     - Encrypt: C,D each rotl by SHIFT[r+1].
//     - Decrypt: C,D each rotr by SHIFT[17-r].
//     - round_idx <= r+1. Back-to-back handshakes give one subkey per cycle.
//   Handshake at r=16: -> IDLE. Next cycle: valid=0, busy=0, round_idx=0, done=1 for exactly one cycle.
//   SHIFT[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Rotations are within each 28-bit half; sum is 28.
//   Boundary conditions:
//     - start during ROUND: ignored, and key/decrypt changes are ignored too.
//     - start in the same cycle done is high: accepted (state is already IDLE).
//     - ready without valid: no effect.
//     - abort in ROUND: next cycle IDLE, valid=0, busy=0, round_idx=0, done stays 0.
//       abort has priority over a same-cycle handshake.
//     - abort in IDLE: no effect; it also blocks a same-cycle start.
//     - rst mid-schedule: identical to reset; no done pulse.
//   subkey is combinational from C/D registers only, with no input-to-output path.
//     subkey = 0 in IDLE because C=D=0 is restored on exit.
// STRUCTURE
//   Shared package des_pkg:
//     - SHIFT table as localparam array [1:16]
//     - state encoding (IDLE, ROUND)
//     - rotl28/rotr28 functions
//   Instantiates the existing combinational PC2 module.
//   Natural sub-module: des_pc1 (64->56 permutation, same [1:N] bit numbering as PC2).
//   FSM, round counter and C/D registers stay in this file.
// TESTING
//   1. key=133457799BBCDFF1, decrypt=0, ready held 1
//      -> valid at N+1; K1=1B02EFFC7072, K2=79AED9DBC9E5, K16=CB3D8B0E17F5
//      -> done pulses at N+17.
//   2. Same key, decrypt=1 -> first subkey CB3D8B0E17F5, second K15, last 1B02EFFC7072.
//      Compare all 16 against the encrypt run reversed.
//   3. Backpressure with random ready
//      -> subkey and round_idx stable while valid & !ready; exactly 16 handshakes; one done pulse.
//   4. key=0 -> all subkeys 000000000000. key=FFFFFFFFFFFFFFFF -> all FFFFFFFFFFFF.
//      Flipping parity bits only -> identical subkeys.
//   5. start pulsed mid-schedule with a different key -> ignored, output sequence unchanged.
//      start in the done cycle -> new schedule begins.
//   6. abort at round 7 and rst at round 12
//      -> next cycle valid=0, busy=0, round_idx=0, no done.
//      A subsequent start produces a correct full sequence.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: shared DES key-schedule constants, state encoding and half-key rotations
package des_pkg;
  typedef enum logic {IDLE, ROUND} state_t;
  localparam logic [1:0] SHIFT [1:16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                          2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  function automatic logic [1:0] shift_at(input logic [4:0] r);
    logic [1:0] s;
    s = 2'd0;
    for (int k = 1; k <= 16; k++) s = (5'(k) == r) ? SHIFT[k] : s;
    return s;
  endfunction
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    return (x << n) | (x >> (5'd28 - 5'(n)));
  endfunction
  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (x >> n) | (x << (5'd28 - 5'(n)));
  endfunction
endpackage

// File: rtl/des_pc1.sv
// des_pc1: DES permuted choice 1, 64-bit key to 56-bit {C0,D0}; bit 1 = MSB
module des_pc1 (
  input  logic [1:64] key,
  output logic [1:56] cd
);
  localparam int PC1_TAB [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4};
  for (genvar i = 1; i <= 56; i++) begin : g_pc1
    assign cd[i] = key[PC1_TAB[i]];
  end
endmodule

// File: rtl/des_pc2.sv
// des_pc2: DES permuted choice 2, 56-bit {C,D} to 48-bit subkey; bit 1 = MSB
module des_pc2 (
  input  logic [1:56] cd,
  output logic [1:48] subkey
);
  localparam int PC2_TAB [1:48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32};
  for (genvar i = 1; i <= 48; i++) begin : g_pc2
    assign subkey[i] = cd[PC2_TAB[i]];
  end
endmodule

// File: rtl/des_key_scheduler.sv
// des_key_scheduler: emits DES subkeys K1..K16 (or K16..K1) one per valid/ready handshake
module des_key_scheduler
  import des_pkg::*;
#(
  parameter int NROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [1:64] key,
  input  logic        abort,
  output logic [1:48] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [4:0]  round_idx,
  output logic        busy,
  output logic        done
);
  state_t      state, state_n;
  logic [1:28] c, d, c_n, d_n;
  logic [1:56] pc1_key;
  logic [4:0]  round_n;
  logic [1:0]  sh;
  logic        dec, dec_n, done_n, hs, last;
  des_pc1 u_pc1 (.key(key), .cd(pc1_key));
  des_pc2 u_pc2 (.cd({c, d}), .subkey(subkey));
  assign subkey_valid = state == ROUND;
  assign busy = subkey_valid;
  assign hs = subkey_valid & subkey_ready;
  assign last = round_idx == 5'(NROUNDS);
  // decrypt walks the schedule backwards, undoing the shift that produced the current round
  assign sh = dec ? shift_at(5'd17 - round_idx) : shift_at(round_idx + 5'd1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c <= '0;
      d <= '0;
      round_idx <= '0;
      dec <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      c <= c_n;
      d <= d_n;
      round_idx <= round_n;
      dec <= dec_n;
      done <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    c_n = c;
    d_n = d;
    round_n = round_idx;
    dec_n = dec;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (start && !abort) begin
        state_n = ROUND;
        dec_n = decrypt;
        round_n = 5'd1;
        c_n = decrypt ? pc1_key[1:28] : rotl28(pc1_key[1:28], SHIFT[1]);
        d_n = decrypt ? pc1_key[29:56] : rotl28(pc1_key[29:56], SHIFT[1]);
      end
    end else if (abort || (hs && last)) begin
      // clearing C/D on exit keeps subkey at zero while idle
      state_n = IDLE;
      c_n = '0;
      d_n = '0;
      round_n = '0;
      done_n = !abort;
    end else if (hs) begin
      c_n = dec ? rotr28(c, sh) : rotl28(c, sh);
      d_n = dec ? rotr28(d, sh) : rotl28(d, sh);
      round_n = round_idx + 5'd1;
    end
  end
endmodule

// File: tb/tb_des_key_scheduler.sv
// tb_des_key_scheduler: directed table-driven checks of the DES key scheduler
module tb_des_key_scheduler;
  logic        clk = 1'b0;
  logic        rst, start, decrypt, abort, subkey_ready;
  logic [1:64] key;
  logic [1:48] subkey;
  logic        subkey_valid, busy, done;
  logic [4:0]  round_idx;
  int          errs = 0;
  int          checks = 0;
  int          hs_cnt;
  int          cyc;
  logic [47:0] got [1:16];
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] EK [1:16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
  typedef struct {
    logic [63:0] key;
    logic        dec;
    logic        rnd;
    logic [1:0]  kind;
  } vec_t;
  vec_t tv [7];

  des_key_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key(key), .abort(abort),
    .subkey(subkey), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .round_idx(round_idx), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] exp_of(input logic [1:0] kind, input logic dc, input int i);
    return kind == 2'd0 ? EK[dc ? 17 - i : i] : kind == 2'd1 ? 48'h0 : {48{1'b1}};
  endfunction

  task automatic do_start(input logic [63:0] k, input logic dc);
    @(negedge clk);
    start = 1'b1;
    key = k;
    decrypt = dc;
    subkey_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("valid_n1", 64'(subkey_valid), 64'd1);
    chk("busy_n1", 64'(busy), 64'd1);
    chk("idx_n1", 64'(round_idx), 64'd1);
    hs_cnt = 0;
  endtask

  task automatic collect_until(input int n, input bit rnd, output int ncyc);
    logic [47:0] last_k;
    logic [4:0]  last_i;
    bit          stalled;
    stalled = 1'b0;
    last_k = '0;
    last_i = '0;
    ncyc = 0;
    while (hs_cnt < n && ncyc < 500) begin
      if (stalled) begin
        chk("hold_key", 64'(subkey), 64'(last_k));
        chk("hold_idx", 64'(round_idx), 64'(last_i));
      end
      subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("valid_in_round", 64'(subkey_valid), 64'd1);
      chk("done_low", 64'(done), 64'd0);
      if (subkey_ready) begin
        hs_cnt++;
        got[hs_cnt] = subkey;
        chk("idx", 64'(round_idx), 64'(hs_cnt));
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        last_k = subkey;
        last_i = round_idx;
      end
      @(negedge clk);
      ncyc++;
    end
    subkey_ready = 1'b0;
    chk("hs_count", 64'(hs_cnt), 64'(n));
  endtask

  task automatic finish_checks(input logic [1:0] kind, input logic dc);
    chk("done_pulse", 64'(done), 64'd1);
    chk("valid_off", 64'(subkey_valid), 64'd0);
    chk("busy_off", 64'(busy), 64'd0);
    chk("idx_idle", 64'(round_idx), 64'd0);
    chk("subkey_idle", 64'(subkey), 64'd0);
    for (int i = 1; i <= 16; i++) chk($sformatf("k%0d", i), 64'(got[i]), 64'(exp_of(kind, dc, i)));
  endtask

  task automatic check_idle_after_cancel(input string tag);
    chk({tag, "_valid"}, 64'(subkey_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idx"}, 64'(round_idx), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_subkey"}, 64'(subkey), 64'd0);
    @(negedge clk);
    chk({tag, "_nodone"}, 64'(done), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0] = '{KEY, 1'b0, 1'b0, 2'd0};
    tv[1] = '{KEY, 1'b1, 1'b0, 2'd0};
    tv[2] = '{KEY, 1'b0, 1'b1, 2'd0};
    tv[3] = '{KEY, 1'b1, 1'b1, 2'd0};
    tv[4] = '{64'h0, 1'b0, 1'b0, 2'd1};
    tv[5] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 2'd2};
    tv[6] = '{KEY ^ 64'h0101010101010101, 1'b0, 1'b0, 2'd0};
    rst = 1'b1;
    start = 1'b0;
    decrypt = 1'b0;
    abort = 1'b0;
    subkey_ready = 1'b0;
    key = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_idx", 64'(round_idx), 64'd0);
    chk("rst_subkey", 64'(subkey), 64'd0);
    rst = 1'b0;
    for (int v = 0; v < 7; v++) begin
      do_start(tv[v].key, tv[v].dec);
      collect_until(16, tv[v].rnd, cyc);
      if (!tv[v].rnd) chk("done_latency", 64'(cyc), 64'd16);
      finish_checks(tv[v].kind, tv[v].dec);
      @(negedge clk);
      chk("done_once", 64'(done), 64'd0);
    end
    // start mid-schedule with another key is ignored; start in the done cycle is taken
    do_start(KEY, 1'b0);
    collect_until(5, 1'b0, cyc);
    start = 1'b1;
    key = '0;
    decrypt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key = KEY;
    chk("ign_idx", 64'(round_idx), 64'd6);
    chk("ign_valid", 64'(subkey_valid), 64'd1);
    chk("ign_key", 64'(subkey), 64'(EK[6]));
    collect_until(16, 1'b0, cyc);
    finish_checks(2'd0, 1'b0);
    start = 1'b1;
    decrypt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_valid", 64'(subkey_valid), 64'd1);
    chk("restart_idx", 64'(round_idx), 64'd1);
    chk("restart_key", 64'(subkey), 64'(EK[16]));
    hs_cnt = 0;
    collect_until(16, 1'b0, cyc);
    finish_checks(2'd0, 1'b1);
    @(negedge clk);
    // abort at round 7 wins over a same-cycle handshake
    do_start(KEY, 1'b0);
    collect_until(6, 1'b0, cyc);
    chk("abort_at_idx", 64'(round_idx), 64'd7);
    abort = 1'b1;
    subkey_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    subkey_ready = 1'b0;
    check_idle_after_cancel("abort");
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_blocks_start", 64'(subkey_valid), 64'd0);
    subkey_ready = 1'b1;
    repeat (2) @(negedge clk);
    subkey_ready = 1'b0;
    chk("ready_idle_idx", 64'(round_idx), 64'd0);
    chk("ready_idle_done", 64'(done), 64'd0);
    do_start(KEY, 1'b0);
    collect_until(16, 1'b0, cyc);
    finish_checks(2'd0, 1'b0);
    @(negedge clk);
    // reset at round 12
    do_start(KEY, 1'b1);
    collect_until(11, 1'b0, cyc);
    chk("rst_at_idx", 64'(round_idx), 64'd12);
    rst = 1'b1;
    subkey_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    subkey_ready = 1'b0;
    check_idle_after_cancel("midrst");
    do_start(KEY, 1'b1);
    collect_until(16, 1'b0, cyc);
    finish_checks(2'd0, 1'b1);
    @(negedge clk);
    chk("final_done_low", 64'(done), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
